// File: rtl/ratio_calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ratio_calc_pkg
//  Description : Shared definitions for the ratio calculator. Holds default
//                operand, result and tag widths, the scale constant, a
//                ceiling-log2 helper, the numerator width helper and the FSM
//                state encoding. The RND state exists only when
//                RATIO_CALC_ROUND_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package ratio_calc_pkg;

    localparam int DEF_W_IN  = 12;
    localparam int DEF_W_OUT = 11;
    localparam int DEF_SCALE = 10000;
    localparam int DEF_TAG_W = 3;

    // Ceiling log2. Returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Numerator width: enough bits to hold A2 * SCALE without truncation.
    function automatic int wn_calc(input int w_in, input int scale);
        return w_in + clog2(scale + 1);
    endfunction

`ifdef RATIO_CALC_ROUND_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_RND  = 3'd3,
        ST_DONE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_DONE = 3'd4
    } state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/ratio_calc_seq_div.sv
`default_nettype none
// ============================================================================
//  Module      : seq_restoring_div
//  Description : Multi-cycle unsigned restoring divider. A start pulse loads
//                the operands; one quotient bit is produced per clock, MSB
//                first, for exactly WN clocks. 'done' is high during the
//                final iteration cycle, so quot/rem are final right after
//                the edge that ends that cycle and then hold until the next
//                start.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_restoring_div
    import ratio_calc_pkg::*;
#(
    parameter int WN = 26,
    parameter int WD = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [WN-1:0] num,
    input  logic [WD-1:0] den,
    output logic          busy,
    output logic          done,
    output logic [WN-1:0] quot,
    output logic [WD-1:0] rem
);

    localparam int            CW     = (clog2(WN) > 0) ? clog2(WN) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WN - 1);

    logic [WN-1:0] quot_q, quot_d;
    logic [WD-1:0] rem_q, rem_d;
    logic [WD-1:0] den_q, den_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    logic [WD:0]   w_trial;
    logic [WD-1:0] w_diff;
    logic          w_ge;
    logic          w_last;

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. The quotient register doubles as the
    // dividend shift register.
    always_comb begin
        w_trial = {rem_q, quot_q[WN-1]};
        w_ge    = (w_trial >= {1'b0, den_q});
        w_diff  = w_trial[WD-1:0] - den_q;
        w_last  = busy_q && (cnt_q == C_LAST);

        quot_d = quot_q;
        rem_d  = rem_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;

        if (start) begin
            quot_d = num;
            rem_d  = '0;
            den_d  = den;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            quot_d = {quot_q[WN-2:0], w_ge};
            rem_d  = w_ge ? w_diff : w_trial[WD-1:0];
            cnt_d  = cnt_q + CW'(1);
            busy_d = !w_last;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            quot_q <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = w_last;
    assign quot = quot_q;
    assign rem  = rem_q;

endmodule
`default_nettype wire

// File: rtl/ratio_calc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ratio_calc_seq
//  Description : Computes Q = (A2 * SCALE) / (A1 - A2) with a sequential
//                restoring divider behind a valid/ready handshake. Carries a
//                channel tag, flags A1 <= A2 as an error and saturates the
//                result at 2^W_OUT-1 with an overflow flag.
//                Define RATIO_CALC_ROUND_EN for round-half-up results (adds
//                one cycle of latency through the RND state).
//  Revision    : 1.0 - initial release
// ============================================================================
module ratio_calc_seq
    import ratio_calc_pkg::*;
#(
    parameter int W_IN  = DEF_W_IN,
    parameter int W_OUT = DEF_W_OUT,
    parameter int SCALE = DEF_SCALE,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_a1,
    input  logic [W_IN-1:0]  in_a2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             out_ovf
);

    localparam int              WN      = wn_calc(W_IN, SCALE);
    localparam logic [WN:0]     C_MAX   = {{(WN + 1 - W_OUT){1'b0}}, {W_OUT{1'b1}}};
    localparam logic [WN-1:0]   C_SCALE = WN'(SCALE);
    localparam logic [W_IN-1:0] C_ONE   = W_IN'(1);

    state_t           state_q, state_d;
    logic [W_IN-1:0]  a1_q, a1_d;
    logic [W_IN-1:0]  a2_q, a2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             err_q, err_d;

    logic             w_start;
    logic             w_err;
    logic [WN-1:0]    w_num;
    logic [W_IN-1:0]  w_den;
    logic             w_div_busy;
    logic             w_div_done;
    logic [WN-1:0]    w_div_quot;
    logic [W_IN-1:0]  w_div_rem;
    logic [WN:0]      w_final;
    logic             w_sat;
    logic             w_done_st;
    logic             w_unused_busy;

    // Operand preparation from the captured request. The divisor is forced
    // to 1 on error so the divider never sees zero or a wrapped difference.
    always_comb begin
        w_err = (a1_q <= a2_q);
        w_num = WN'(a2_q) * C_SCALE;
        w_den = w_err ? C_ONE : (a1_q - a2_q);
    end

    seq_restoring_div #(
        .WN (WN),
        .WD (W_IN)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .num   (w_num),
        .den   (w_den),
        .busy  (w_div_busy),
        .done  (w_div_done),
        .quot  (w_div_quot),
        .rem   (w_div_rem)
    );

    assign w_unused_busy = w_div_busy;

`ifdef RATIO_CALC_ROUND_EN
    logic [WN:0] rnd_q, rnd_d;
    logic        w_rnd_up;

    // Round half up: bump the quotient when the remainder is at least half
    // the divisor. Kept one bit wider so saturation sees the carry.
    always_comb begin
        w_rnd_up = ({w_div_rem, 1'b0} >= {1'b0, w_den});
        rnd_d    = (state_q == ST_RND) ?
                   ({1'b0, w_div_quot} + {{WN{1'b0}}, w_rnd_up}) : rnd_q;
        w_final  = rnd_q;
    end

    // Rounded quotient register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_q <= '0;
        end else begin
            rnd_q <= rnd_d;
        end
    end
`else
    logic w_unused_rem;

    // Truncating result straight from the divider.
    always_comb begin
        w_final      = {1'b0, w_div_quot};
        w_unused_rem = ^w_div_rem;
    end
`endif

    // Sequencer: capture, start the divider, wait, then hold the result
    // until the consumer takes it.
    always_comb begin
        state_d = state_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        tag_d   = tag_q;
        err_d   = err_q;
        w_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a1_d    = in_a1;
                    a2_d    = in_a2;
                    tag_d   = in_tag;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                w_start = 1'b1;
                err_d   = w_err;
                state_d = ST_DIV;
            end
            ST_DIV: begin
                if (w_div_done) begin
`ifdef RATIO_CALC_ROUND_EN
                    state_d = ST_RND;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef RATIO_CALC_ROUND_EN
            ST_RND: begin
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a1_q    <= '0;
            a2_q    <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
        end
    end

    // Output mapping. Everything is zero outside DONE, and in DONE the
    // values come from registers that do not move, so they stay stable
    // under back-pressure.
    always_comb begin
        w_done_st = (state_q == ST_DONE);
        w_sat     = (w_final > C_MAX);

        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = w_done_st;
        out_err   = w_done_st && err_q;
        out_ovf   = w_done_st && !err_q && w_sat;
        out_tag   = w_done_st ? tag_q : '0;

        if (!w_done_st) begin
            out_result = '0;
        end else if (err_q || w_sat) begin
            out_result = C_MAX[W_OUT-1:0];
        end else begin
            out_result = w_final[W_OUT-1:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ratio_calc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ratio_calc_seq
//  Description : Self-checking bench for ratio_calc_seq. Expected results are
//                computed by a reference model when a request is driven and
//                queued; they are popped and compared when out_valid appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ratio_calc_seq;

    localparam int W_IN  = 12;
    localparam int W_OUT = 11;
    localparam int SCALE = 10000;
    localparam int TAG_W = 3;
    localparam int MAXV  = (1 << W_OUT) - 1;
`ifdef RATIO_CALC_ROUND_EN
    localparam int LAT = 28;
`else
    localparam int LAT = 27;
`endif

    typedef struct {
        logic [W_OUT-1:0] result;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W_IN-1:0]  in_a1;
    logic [W_IN-1:0]  in_a2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W_OUT-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic             out_ovf;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned acc_cyc = 0;

    ratio_calc_seq #(
        .W_IN  (W_IN),
        .W_OUT (W_OUT),
        .SCALE (SCALE),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a1      (in_a1),
        .in_a2      (in_a2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .out_ovf    (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model using plain integer division.
    function automatic exp_t model(input int unsigned a1, input int unsigned a2,
                                   input int unsigned tag);
        exp_t e;
        longint unsigned num;
        longint unsigned den;
        longint unsigned q;
        e.tag = tag[TAG_W-1:0];
        e.err = 1'b0;
        e.ovf = 1'b0;
        if (a1 <= a2) begin
            e.err    = 1'b1;
            e.result = MAXV[W_OUT-1:0];
        end else begin
            num = longint'(a2) * longint'(SCALE);
            den = longint'(a1 - a2);
            q   = num / den;
`ifdef RATIO_CALC_ROUND_EN
            if (2 * (num % den) >= den) q = q + 1;
`endif
            if (q > longint'(MAXV)) begin
                e.ovf    = 1'b1;
                e.result = MAXV[W_OUT-1:0];
            end else begin
                e.result = q[W_OUT-1:0];
            end
        end
        return e;
    endfunction

    task automatic send(input int unsigned a1, input int unsigned a2,
                        input int unsigned tag, input bit expect_result);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: in_ready=%b required 1 (tag %0d)", in_ready, tag);
        end
        in_valid = 1'b1;
        in_a1    = a1[W_IN-1:0];
        in_a2    = a2[W_IN-1:0];
        in_tag   = tag[TAG_W-1:0];
        if (expect_result) sb.push_back(model(a1, a2, tag));
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic collect(input int hold, input bit chk_lat);
        exp_t             e;
        int               w;
        int unsigned      lat;
        logic [W_OUT-1:0] r0;
        logic [TAG_W-1:0] t0;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (out_valid !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
            return;
        end
        lat = cyc - acc_cyc;
        if (chk_lat) begin
            n_tests++;
            if (lat !== LAT) begin
                n_fail++;
                $display("FAIL latency: got %0d cycles required %0d", lat, LAT);
            end
        end
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: result=%0d tag=%0d required none", out_result, out_tag);
        end else begin
            e = sb.pop_front();
            n_tests++;
            if (out_result !== e.result) begin
                n_fail++;
                $display("FAIL result: got %0d required %0d (tag %0d)", out_result, e.result, e.tag);
            end
            n_tests++;
            if (out_tag !== e.tag) begin
                n_fail++;
                $display("FAIL tag: got %0d required %0d", out_tag, e.tag);
            end
            n_tests++;
            if (out_err !== e.err) begin
                n_fail++;
                $display("FAIL err: got %b required %b (tag %0d)", out_err, e.err, e.tag);
            end
            n_tests++;
            if (out_ovf !== e.ovf) begin
                n_fail++;
                $display("FAIL ovf: got %b required %b (tag %0d)", out_ovf, e.ovf, e.tag);
            end
        end
        r0 = out_result;
        t0 = out_tag;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || out_result !== r0 || out_tag !== t0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable: valid=%b result=%0d tag=%0d in_ready=%b required 1/%0d/%0d/0",
                         out_valid, out_result, out_tag, in_ready, r0, t0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_consume: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a1     = '0;
        in_a2     = '0;
        in_tag    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 0", in_ready);
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b required 0", out_valid);
        end
        n_tests++;
        if (out_result !== '0 || out_tag !== '0 || out_err !== 1'b0 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: result=%0d tag=%0d err=%b ovf=%b required all 0",
                     out_result, out_tag, out_err, out_ovf);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        send(4000, 400, 1, 1'b1);
        collect(0, 1'b1);
        send(3000, 100, 3, 1'b1);
        collect(0, 1'b1);
    endtask

    task automatic test_overflow();
        send(2000, 1000, 4, 1'b1);
        collect(0, 1'b1);
    endtask

    task automatic test_error();
        send(500, 500, 7, 1'b1);
        collect(0, 1'b1);
        send(100, 300, 0, 1'b1);
        collect(0, 1'b1);
    endtask

    task automatic test_backpressure();
        send(4000, 400, 1, 1'b1);
        collect(10, 1'b1);
    endtask

    task automatic test_back_to_back();
        send(4000, 400, 5, 1'b1);
        // Second request held on the bus while the first is in flight.
        in_valid = 1'b1;
        in_a1    = 12'd3000;
        in_a2    = 12'd100;
        in_tag   = 3'd2;
        sb.push_back(model(3000, 100, 2));
        collect(0, 1'b1);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        collect(0, 1'b1);
    endtask

    task automatic test_reset_mid();
        bit seen;
        send(3000, 100, 6, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_in_ready: got %b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL midrst_no_output: out_valid seen=1 required 0");
        end
        send(4000, 400, 2, 1'b1);
        collect(0, 1'b1);
    endtask

    task automatic test_random();
        int unsigned a1;
        int unsigned a2;
        for (int i = 0; i < 6; i++) begin
            a1 = $urandom_range(0, 4095);
            a2 = $urandom_range(0, 4095);
            send(a1, a2, i % 8, 1'b1);
            collect(0, 1'b1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_error();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
